demux16_deser: RTL and testbench

- Sequential 1-to-16 demultiplexer and deserializer; the receive-side counterpart of the 16:1 mux.
- A mux stepping its select 0..15 over a 16-bit word produces a serial bit stream. This block steers each incoming bit into word slot sel, with sel driven by an internal counter.
- When all 16 slots are filled, the word is presented through a valid/ready output buffer.
- It sits at the far end of a serial link fed by the mux path.

---
 rtl/demux16_deser.sv | 70 +++++++
 tb/tb_demux16_deser.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux16_deser.sv
// Serial-to-parallel 1:16 demultiplexer: steers each accepted bit into slot sel of a
// collect register and hands completed words to a one-entry valid/ready output buffer.
module demux16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_collect;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic w_last_slot;
  logic w_accept;
  logic w_load;
  logic w_consume;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready. Only the word-completing bit can stall, and only while
  // a finished word is still waiting and is not being consumed in the same cycle.
  assign w_last_slot = (r_sel == LAST_SLOT);
  assign in_ready    = !(w_last_slot && r_out_valid && !out_ready);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_load      = w_accept && w_last_slot;
  assign w_consume   = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_collect <= '0;
    end else if (flush) begin
      r_sel     <= '0;
      r_collect <= '0;
    end else if (w_accept) begin
      r_collect[r_sel] <= in;
      r_sel            <= r_sel + SEL_W'(1);
    end
  end

  // Output buffer: a load may coincide with a consume, so the word stream has no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= {in, r_collect[WIDTH-2:0]};
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_demux16_deser.sv
// Directed bench for demux16_deser: linear sequence of steps with immediate-assertion checks.
module tb_demux16_deser;

  logic        clk;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  demux16_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    in       = b;
    in_valid = 1'b1;
    tick();
  endtask

  logic [15:0] word;
  logic [15:0] words [4];

  initial begin
    rst       = 1'b1;
    in        = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #10;
    rst = 1'b0;
    tick();

    // basic word, back-to-back bits
    word = 16'h3f0a;
    for (int k = 0; k < 16; k++) begin
      check("basic_sel", 32'(sel), 32'(k));
      check("basic_in_ready", 32'(in_ready), 32'd1);
      check("basic_no_early_valid", 32'(out_valid), 32'd0);
      drive_bit(word[k]);
    end
    in_valid = 1'b0;
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out", 32'(out), 32'h3f0a);
    check("basic_sel_wrap", 32'(sel), 32'd0);
    tick();
    check("basic_one_cycle", 32'(out_valid), 32'd0);
    check("basic_out_kept", 32'(out), 32'h3f0a);

    // gapped input: 16 accepts with 15 gap cycles in between
    for (int k = 0; k < 16; k++) begin
      drive_bit(word[k]);
      if (k < 15) begin
        in_valid = 1'b0;
        tick();
        check("gap_sel_hold", 32'(sel), 32'(k + 1));
        check("gap_no_valid", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    check("gap_out_valid", 32'(out_valid), 32'd1);
    check("gap_out", 32'(out), 32'h3f0a);
    tick();
    check("gap_consumed", 32'(out_valid), 32'd0);

    // backpressure
    out_ready = 1'b0;
    word = 16'hA5C3;
    for (int k = 0; k < 16; k++) drive_bit(word[k]);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_out", 32'(out), 32'hA5C3);
    word = 16'h1234;
    for (int k = 0; k < 15; k++) begin
      check("bp_accept_partial", 32'(in_ready), 32'd1);
      drive_bit(word[k]);
    end
    check("bp_sel15", 32'(sel), 32'd15);
    check("bp_stall", 32'(in_ready), 32'd0);
    drive_bit(word[15]);
    check("bp_sel_held", 32'(sel), 32'd15);
    check("bp_out_held", 32'(out), 32'hA5C3);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second_out", 32'(out), 32'h1234);
    check("bp_valid_stays", 32'(out_valid), 32'd1);
    check("bp_sel_wrap", 32'(sel), 32'd0);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // flush mid-word
    word = 16'h0055;
    for (int k = 0; k < 7; k++) drive_bit(word[k]);
    check("flush_pre_sel", 32'(sel), 32'd7);
    flush = 1'b1;
    drive_bit(1'b1);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_sel", 32'(sel), 32'd0);
    check("flush_no_valid", 32'(out_valid), 32'd0);
    word = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      check("flush_refill_no_valid", 32'(out_valid), 32'd0);
      drive_bit(word[k]);
    end
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd1);
    check("flush_out", 32'(out), 32'hFFFF);
    tick();

    // back-to-back words
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'hFFFF;
    words[3] = 16'h0000;
    for (int w = 0; w < 4; w++) begin
      word = words[w];
      for (int k = 0; k < 16; k++) begin
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        drive_bit(word[k]);
        check("b2b_valid_pulse", 32'(out_valid), (k == 15) ? 32'd1 : 32'd0);
        if (k == 15) check("b2b_out", 32'(out), 32'(words[w]));
      end
    end
    in_valid = 1'b0;
    tick();
    check("b2b_done", 32'(out_valid), 32'd0);

    // async reset mid-word with a word pending
    out_ready = 1'b0;
    word = 16'hBEEF;
    for (int k = 0; k < 16; k++) drive_bit(word[k]);
    for (int k = 0; k < 10; k++) drive_bit(word[k]);
    in_valid = 1'b0;
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    check("arst_pre_sel", 32'(sel), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_out", 32'(out), 32'h0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    #5;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("arst_after_sel", 32'(sel), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
